serial_ripple_subtractor: RTL and testbench

//  Bit-serial subtractor: computes diff = a - b - bin over WIDTH cycles, LSB first, with one

---
 rtl/serial_ripple_subtractor_pkg.sv | 16 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_ripple_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_ripple_subtractor_pkg;

  // Operation sequencing: wait for start, shift bits through the cell, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the bit counter for a given operand width (never narrower than one bit).
  function automatic int cnt_width(input int width);
    cnt_width = (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out; a borrow arises when b exceeds a, or when
  // a equals b and a borrow is already pending.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin computed LSB first over
// WIDTH cycles with a single full-subtractor cell and a registered borrow.
// Start/done handshake; the result is held until the next operation finishes.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             brw_q,     brw_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             bout_q,    bout_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] diff_sh_nxt;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    diff_sh_nxt = (diff_sh_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
  end

  // Next-state and datapath control; a start in DONE is accepted like one in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    brw_d     = brw_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = b;
          brw_d     = bin;
          diff_sh_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        brw_d     = fs_bout;
        diff_sh_d = diff_sh_nxt;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          diff_d  = diff_sh_nxt;
          bout_d  = fs_bout;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      brw_q     <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      brw_q     <= brw_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at WIDTH 4, 8 and 1.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = 4'd0, b4 = 4'd0, diff4;
  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = 8'd0, b8 = 8'd0, diff8;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

  serial_ripple_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

  serial_ripple_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=4 operation; operands are scrambled right after acceptance.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic bin, input logic [3:0] ed, input logic eb);
    int n;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
    check({tag, "_busy"}, 32'(busy4), 32'd1);
    n = 0;
    while (!done4 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_diff"}, 32'(diff4), 32'(ed));
    check({tag, "_bout"}, 32'(bout4), 32'(eb));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done4), 32'd0);
    check({tag, "_hold"}, 32'({bout4, diff4}), 32'({eb, ed}));
  endtask

  // One WIDTH=1 operation.
  task automatic op1(input string tag, input logic a, input logic b, input logic bin,
                     input logic ed, input logic eb);
    int n;
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 32'(n), 32'd1);
    check({tag, "_res"}, 32'({bout1, diff1}), 32'({eb, ed}));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int seen;
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rbin;

    #12;
    check("rst_state", 32'({busy4, done4, bout4, diff4}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op4("t1", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    op4("t2a", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    op4("t2b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    op4("t3a", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);
    op4("t3b", 4'hF, 4'd0, 1'b1, 4'hE, 1'b0);

    // Start pulsed while busy must be ignored.
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd2; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 2;
    while (!done4 && n < 20) begin @(posedge clk); #1; n++; end
    check("t4_lat", 32'(n), 32'd4);
    check("t4_res", 32'({bout4, diff4}), 32'({1'b0, 4'd5}));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen++;
    end
    check("t4_noqueue", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of RUN (diff currently holds 5).
    a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t5_clear", 32'({busy4, done4, bout4, diff4}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) seen++;
    end
    check("t5_nodone", 32'(seen), 32'd0);
    op4("t5_next", 4'd12, 4'd3, 1'b0, 4'd9, 1'b0);

    // WIDTH=1 boundary.
    op1("w1a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    op1("w1b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op1("w1c", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    op1("w1d", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // WIDTH=8, back-to-back starts on every done cycle with random operands.
    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    a8 = ra; b8 = rb; bin8 = rbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      model = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      n = 0;
      while (!done8 && n < 30) begin @(posedge clk); #1; n++; end
      check("t6_lat", 32'(n), 32'd8);
      check("t6_res", 32'({bout8, diff8}), 32'(model));
      if (i < 999) begin
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        a8 = ra; b8 = rb; bin8 = rbin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~ra; b8 = ~rb; bin8 = ~rbin;
        check("t6_b2b_busy", 32'(busy8), 32'd1);
        check("t6_hold", 32'({bout8, diff8}), 32'(model));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
